rf_write_arbiter: RTL and testbench

- Owns the single write port of the CPU register file and merges two writers onto it.
- Writer 1: the pipeline writeback stage, which never stalls. Writer 2: an auxiliary multi-cycle producer (mul/div unit, coprocessor) using a valid/ready handshake, buffered in a small FIFO.
- Drives registered rf_we/rf_waddr/rf_wdata into the register file.
- Exposes a pending-write lookup so the hazard unit can stall readers of registers with queued aux results.

---
 rtl/wb_pkg.sv | 10 +
 rtl/wbq_fifo.sv | 47 ++++
 rtl/rf_write_arbiter.sv | 97 +++++++++
 tb/tb_rf_write_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, register-file write entry type and the r0 constant
package wb_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wbq_fifo.sv
// wbq_fifo: aux write-result FIFO with per-slot valid/rd taps for hazard matching
// Ports: clk, reset (async, active-high); push/push_entry enqueue; pop dequeues head;
//        head = oldest entry; count = occupancy; vld/rds = per-slot valid bit and rd.
module wbq_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  wb_entry_t                        push_entry,
  input  logic                             pop,
  output wb_entry_t                        head,
  output logic [CW-1:0]                    count,
  output logic [DEPTH-1:0]                 vld,
  output logic [DEPTH-1:0][REG_W-1:0]      rds
);
  wb_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  genvar g;
  assign head = mem[rd_ptr];
  for (g = 0; g < DEPTH; g++) begin : g_rd
    assign rds[g] = mem[g].rd;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end
  // Pointers wrap naturally since DEPTH is a power of two. The caller never
  // pushes when full, so a same-cycle push and pop always touch different slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (pop) vld[rd_ptr] <= 1'b0;
      if (push) vld[wr_ptr] <= 1'b1;
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: merges the writeback stage and a buffered aux producer onto the RF write port
// Ports: clk, reset (async, active-high)
//        wb_en/wb_rd/wb_data      pipeline writeback (never stalls, highest priority)
//        aux_valid/aux_ready/aux_rd/aux_data  aux producer handshake into the FIFO
//        rf_we/rf_waddr/rf_wdata  registered register-file write
//        q_rd/q_pending           hazard query: aux write to q_rd still in flight
//        stall_req                ask the pipeline to drop wb_en for a cycle
//        count                    FIFO occupancy
//        conflict_cycles          only with RF_WRITE_ARB_STATS_EN: saturating count of
//                                 cycles the queue waited behind a primary write
module rf_write_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [REG_W-1:0]  aux_rd,
  input  logic [DATA_W-1:0] aux_data,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [REG_W-1:0]  q_rd,
  output logic              q_pending,
  output logic              stall_req,
  output logic [CW-1:0]     count
`ifdef RF_WRITE_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cycles
`endif
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  wb_entry_t head;
  logic [DEPTH-1:0] vld, match;
  logic [DEPTH-1:0][REG_W-1:0] rds;
  logic prim, empty, pop, push, from_aux;
  logic [SW-1:0] starve, starve_nxt;
  genvar g;
  assign aux_ready = count < CW'(DEPTH);
  assign prim = wb_en && wb_rd != REG_ZERO;
  assign empty = count == '0;
  assign pop = !prim && !empty;
  // r0 writes complete the handshake but are never stored
  assign push = aux_valid && aux_ready && aux_rd != REG_ZERO;
  // Counts cycles the head lost to the primary; saturates so stall_req holds until a pop
  assign starve_nxt = (pop || empty) ? '0 : (starve == SW'(STARVE_LIMIT)) ? starve : starve + 1'b1;
  for (g = 0; g < DEPTH; g++) begin : g_match
    assign match[g] = vld[g] && rds[g] == q_rd;
  end
  assign q_pending = q_rd != REG_ZERO && (|match || (rf_we && from_aux && rf_waddr == q_rd));
  wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry ('{rd: aux_rd, data: aux_data}),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .vld        (vld),
    .rds        (rds)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      from_aux  <= 1'b0;
      starve    <= '0;
      stall_req <= 1'b0;
    end else begin
      rf_we    <= prim || pop;
      from_aux <= pop;
      if (prim) begin
        rf_waddr <= wb_rd;
        rf_wdata <= wb_data;
      end else if (pop) begin
        rf_waddr <= head.rd;
        rf_wdata <= head.data;
      end
      starve    <= starve_nxt;
      stall_req <= starve_nxt == SW'(STARVE_LIMIT);
    end
  end
`ifdef RF_WRITE_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) conflict_cycles <= '0;
    else if (prim && !empty && conflict_cycles != 16'hFFFF) conflict_cycles <= conflict_cycles + 1'b1;
  end
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: table vectors, directed corner sequences and random stimulus vs a queue model
module tb_rf_write_arbiter;
  localparam int DEPTH = 4;
  localparam int LIM = 8;
  logic clk, reset, wb_en, aux_valid, aux_ready, rf_we, q_pending, stall_req;
  logic [4:0] wb_rd, aux_rd, rf_waddr, q_rd;
  logic [31:0] wb_data, aux_data, rf_wdata;
  logic [2:0] count;
`ifdef RF_WRITE_ARB_STATS_EN
  logic [15:0] conflict_cycles;
`endif
  int checks = 0, errors = 0;
  logic [4:0] mrd[$];
  logic [31:0] mdat[$];
  logic m_we, m_from_aux, m_stall;
  logic [4:0] m_waddr;
  logic [31:0] m_wdata;
  int m_starve, m_conf;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_rd(aux_rd), .aux_data(aux_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .q_rd(q_rd),
    .q_pending(q_pending), .stall_req(stall_req), .count(count)
`ifdef RF_WRITE_ARB_STATS_EN
    , .conflict_cycles(conflict_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic wb_en; logic [4:0] wb_rd; logic [31:0] wb_data;
    logic aux_valid; logic [4:0] aux_rd; logic [31:0] aux_data;
    logic e_we; logic [4:0] e_addr; logic [31:0] e_data; int e_count;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_pending();
    if (q_rd == 5'd0) return 1'b0;
    foreach (mrd[i]) if (mrd[i] == q_rd) return 1'b1;
    return m_we && m_from_aux && m_waddr == q_rd;
  endfunction

  task automatic model_reset();
    mrd.delete(); mdat.delete();
    m_we = 0; m_from_aux = 0; m_stall = 0; m_waddr = 0; m_wdata = 0; m_starve = 0; m_conf = 0;
  endtask

  task automatic model_step();
    bit prim = wb_en && wb_rd != 5'd0;
    bit ne = mrd.size() > 0;
    bit rdy = mrd.size() < DEPTH;
    if (prim) begin
      m_we = 1; m_waddr = wb_rd; m_wdata = wb_data; m_from_aux = 0;
    end else if (ne) begin
      m_we = 1; m_waddr = mrd.pop_front(); m_wdata = mdat.pop_front(); m_from_aux = 1;
    end else begin
      m_we = 0; m_from_aux = 0;
    end
    if (aux_valid && rdy && aux_rd != 5'd0) begin
      mrd.push_back(aux_rd); mdat.push_back(aux_data);
    end
    if (prim && ne) begin
      m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
      if (m_conf < 65535) m_conf++;
    end else m_starve = 0;
    m_stall = m_starve == LIM;
  endtask

  task automatic tick();
    #1;
    chk("aux_ready", 32'(aux_ready), 32'(mrd.size() < DEPTH));
    chk("count", 32'(count), 32'(mrd.size()));
    chk("q_pending", 32'(q_pending), 32'(exp_pending()));
    chk("rf_we", 32'(rf_we), 32'(m_we));
    chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("stall_req", 32'(stall_req), 32'(m_stall));
`ifdef RF_WRITE_ARB_STATS_EN
    chk("conflict_cycles", 32'(conflict_cycles), 32'(m_conf));
`endif
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en = 0; wb_rd = 0; wb_data = 0; aux_valid = 0; aux_rd = 0; aux_data = 0;
  endtask

  initial begin
    int n;
    idle(); q_rd = 0; reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_we", 32'(rf_we), 0);
    chk("reset_count", 32'(count), 0);
    chk("reset_aux_ready", 32'(aux_ready), 1);
    chk("reset_stall", 32'(stall_req), 0);
    chk("reset_waddr", 32'(rf_waddr), 0);
    chk("reset_wdata", rf_wdata, 0);
    reset = 0;

    tbl[0] = '{1, 5'd3, 32'h1234, 0, 5'd0, 32'h0,  1, 5'd3, 32'h1234, 0};
    tbl[1] = '{0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  0, 5'd3, 32'h1234, 0};
    tbl[2] = '{1, 5'd0, 32'h77,   1, 5'd4, 32'h44, 0, 5'd3, 32'h1234, 1};
    tbl[3] = '{1, 5'd0, 32'h88,   1, 5'd0, 32'h55, 1, 5'd4, 32'h44,   0};
    tbl[4] = '{0, 5'd0, 32'h0,    0, 5'd0, 32'h0,  0, 5'd4, 32'h44,   0};
    for (int i = 0; i < 5; i++) begin
      wb_en = tbl[i].wb_en; wb_rd = tbl[i].wb_rd; wb_data = tbl[i].wb_data;
      aux_valid = tbl[i].aux_valid; aux_rd = tbl[i].aux_rd; aux_data = tbl[i].aux_data;
      tick();
      chk($sformatf("tbl%0d_we", i), 32'(rf_we), 32'(tbl[i].e_we));
      chk($sformatf("tbl%0d_addr", i), 32'(rf_waddr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_data", i), rf_wdata, tbl[i].e_data);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_count));
    end

    // fill the FIFO behind a continuous primary, then drain in order
    idle(); wb_en = 1; wb_rd = 1; wb_data = 32'hFF;
    for (int i = 0; i < 4; i++) begin
      aux_valid = 1; aux_rd = 5'(5 + i); aux_data = 32'hA0 + 32'(i);
      tick();
    end
    chk("full_ready", 32'(aux_ready), 0);
    chk("full_count", 32'(count), 4);
    aux_rd = 5'd11; aux_data = 32'hEE;
    tick();
    chk("full_reject", 32'(count), 4);
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_we", 32'(rf_we), 1);
      chk("drain_addr", 32'(rf_waddr), 32'(5 + i));
      chk("drain_data", rf_wdata, 32'hA0 + 32'(i));
    end
    tick();
    chk("drain_done", 32'(rf_we), 0);

    // starvation
    wb_en = 1; wb_rd = 2; wb_data = 32'h22; aux_valid = 1; aux_rd = 9; aux_data = 32'h99;
    tick();
    aux_valid = 0;
    n = 0;
    while (!stall_req && n < 20) begin
      tick();
      n++;
    end
    chk("starve_cycles", 32'(n), LIM);
    wb_en = 0;
    tick();
    chk("starve_we", 32'(rf_we), 1);
    chk("starve_addr", 32'(rf_waddr), 9);
    chk("starve_stall_drop", 32'(stall_req), 0);
    chk("starve_count", 32'(count), 0);

    // q_pending tracks an aux write until it leaves the output register
    idle(); q_rd = 10; wb_en = 1; wb_rd = 2; aux_valid = 1; aux_rd = 10; aux_data = 32'hBEEF;
    tick();
    aux_valid = 0;
    chk("qp_queued", 32'(q_pending), 1);
    q_rd = 0;
    #1;
    chk("qp_r0", 32'(q_pending), 0);
    q_rd = 10;
    tick();
    chk("qp_still", 32'(q_pending), 1);
    wb_en = 0;
    tick();
    chk("qp_write", 32'(rf_waddr), 10);
    chk("qp_in_oreg", 32'(q_pending), 1);
    tick();
    chk("qp_clear", 32'(q_pending), 0);

    // reset mid-operation
    idle(); wb_en = 1; wb_rd = 2;
    for (int i = 0; i < 3; i++) begin
      aux_valid = 1; aux_rd = 5'(12 + i); aux_data = 32'(i);
      tick();
    end
    idle();
    #2;
    reset = 1;
    #1;
    chk("mid_reset_count", 32'(count), 0);
    chk("mid_reset_we", 32'(rf_we), 0);
    chk("mid_reset_ready", 32'(aux_ready), 1);
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
    repeat (4) tick();

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      wb_en = $urandom_range(0, 9) < 6;
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      aux_valid = $urandom_range(0, 1) == 1;
      aux_rd = 5'($urandom_range(0, 12));
      aux_data = $urandom;
      q_rd = 5'($urandom_range(0, 12));
      tick();
    end
    idle();
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
